// File: rtl/instr_assembler.sv
// Variable-length instruction register: assembles 1..MAX_BYTES fetch bytes into a held word.
// Optional branch-redirect flush input enabled by defining INSTR_ASM_FLUSH_EN.
module instr_assembler #(
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned MAX_BYTES = 3,
  parameter int unsigned LEN_W     = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
`ifdef INSTR_ASM_FLUSH_EN
  input  logic                               flush,
`endif
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BYTE_W-1:0]                  in_byte,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [BYTE_W*MAX_BYTES-1:0]        instr,
  output logic [$clog2(MAX_BYTES+1)-1:0]     instr_len,
  output logic                               len_err
);

  localparam int unsigned CNT_W  = $clog2(MAX_BYTES + 1);
  localparam int unsigned WORD_W = BYTE_W * MAX_BYTES;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    target_q, target_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [WORD_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic                out_valid_q, out_valid_d;
  logic                len_err_q, len_err_d;
  logic [LEN_W-1:0]    code;
  logic                accept;

  // Ready is held low during reset and whenever an instruction is waiting for the decoder.
`ifdef INSTR_ASM_FLUSH_EN
  assign in_ready = rst_n && (state_q != HOLD) && !flush;
`else
  assign in_ready = rst_n && (state_q != HOLD);
`endif

  assign code   = in_byte[BYTE_W-1 -: LEN_W];
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      target_q    <= '0;
      buf_q       <= '0;
      instr_q     <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      target_q    <= target_d;
      buf_q       <= buf_d;
      instr_q     <= instr_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      len_err_q   <= len_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    target_d    = target_q;
    buf_d       = buf_q;
    instr_d     = instr_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    len_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (32'(code) >= MAX_BYTES) begin
            len_err_d = 1'b1;
          end else if (code == '0) begin
            instr_d                        = '0;
            instr_d[WORD_W-1 -: BYTE_W]    = in_byte;
            len_d                          = CNT_W'(1);
            out_valid_d                    = 1'b1;
            state_d                        = HOLD;
          end else begin
            buf_d                          = '0;
            buf_d[WORD_W-1 -: BYTE_W]      = in_byte;
            target_d                       = CNT_W'(32'(code) + 32'd1);
            count_d                        = CNT_W'(1);
            state_d                        = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          // Slot index counts from the MSB end of the word.
          for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (count_q == CNT_W'(i)) buf_d[WORD_W-1-i*BYTE_W -: BYTE_W] = in_byte;
          end
          count_d = count_q + CNT_W'(1);
          if (count_d == target_q) begin
            instr_d     = buf_d;
            len_d       = target_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          count_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef INSTR_ASM_FLUSH_EN
    // Redirect discards any partial or held instruction.
    if (flush) begin
      state_d     = IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
      len_err_d   = 1'b0;
    end
`endif
  end

  assign instr     = instr_q;
  assign instr_len = len_q;
  assign out_valid = out_valid_q;
  assign len_err   = len_err_q;

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
Parametrised instruction register. It assembles a variable-length instruction, 1..MAX_BYTES bytes, from a byte-serial fetch stream using a valid/ready handshake. The length is decoded from a length field in the first byte. The assembled word is held until the decode stage accepts it. It sits between the memory fetch unit and the instruction decoder.

Parameters:
BYTE_W, 8, width of one fetched byte
MAX_BYTES, 3, maximum instruction length in bytes (legal range 1..8)
LEN_W, 2, width of the length code at the MSBs of the first byte; length = code+1

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch byte available
in_ready  out  1  block accepts byte this cycle
in_byte  in  BYTE_W  fetched byte
out_valid  out  1  assembled instruction available
out_ready  in  1  decoder accepts instruction
instr  out  BYTE_W*MAX_BYTES  assembled instruction; first byte in MSBs, unused low bytes zero
instr_len  out  clog2(MAX_BYTES+1)  byte count of instr
len_err  out  1  one-cycle pulse: illegal length code seen

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, byte count=0.
  - instr=0, instr_len=0, out_valid=0, len_err=0.
  - in_ready goes low immediately, because it is combinational from state.
- A transfer happens on an edge where in_valid && in_ready; the same rule applies to out_valid && out_ready.
- in_ready = 1 in IDLE and COLLECT, 0 in HOLD. No byte is accepted while an instruction is held.
- IDLE, byte accepted:
  - code = in_byte[BYTE_W-1 -: LEN_W]; len = code+1.
  - len > MAX_BYTES: byte discarded, len_err=1 for exactly the next cycle, stay IDLE.
  - len == 1: instr = {in_byte, zeros}, instr_len=1, go to HOLD. out_valid is high the cycle after the accepting edge (latency 1).
  - else: store byte 0, target=len, count=1, go to COLLECT.
- COLLECT, byte accepted:
  - Store into byte slot `count`, then count+1.
  - When count+1 == target: drive instr with all target bytes left-aligned, low slots zeroed; instr_len=target; go to HOLD.
- HOLD:
  - out_valid=1; instr and instr_len are stable until the handshake.
  - On out_ready: out_valid falls next cycle, count=0, go to IDLE.
  - One dead input cycle after handoff is accepted (max throughput = one instruction per len+1 cycles).
- in_valid low in COLLECT: wait indefinitely, partial bytes retained.
- out_valid never drops without out_ready.
- instr and instr_len hold their last value in IDLE/COLLECT; they are meaningful only while out_valid=1.
- Reset mid-COLLECT or mid-HOLD: partial or held instruction is lost, block returns to IDLE.
- Width rules:
  - byte slots indexed from the MSB.
  - count width clog2(MAX_BYTES+1); no wrap, count never exceeds MAX_BYTES.
  - Length codes above MAX_BYTES-1 are illegal.

Optional Feature:
INSTR_ASM_FLUSH_EN
- Defined:
  - Adds input port flush (1 bit), synchronous, highest priority over all transfers.
  - On a flush edge: state=IDLE, count=0, out_valid=0.
  - The byte offered that cycle is not accepted (in_ready forced 0 while flush=1).
  - len_err is not asserted.
  - Used on branch redirect.
- Not defined: port absent, no flush logic.

Test Plan:
- Reset, then send 0x05 (code 00) -> out_valid high next cycle; instr=0x050000, instr_len=1; HOLD until out_ready.
- Send 0x4A, 0x11 (code 01) -> instr=0x4A1100, instr_len=2.
- Send 0x8C, 0x22, 0x33 with in_valid gaps of 2 cycles between bytes -> instr=0x8C2233, instr_len=3; no byte lost.
- Send 0xC0 (code 11, MAX_BYTES=3) -> len_err pulses 1 cycle; out_valid stays 0; next 0x05 assembles normally.
- Hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0, instr stable; on out_ready=1, the next byte is accepted one cycle later.
- Deassert rst_n mid-COLLECT after 0x8C, 0x22 -> outputs zero immediately; next sequence 0x4A, 0x11 gives instr=0x4A1100. With INSTR_ASM_FLUSH_EN defined, a flush after 0x8C has the same effect.
